// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game datapath: default sizes,
// pointer/pattern types and the one-hot pattern test.
package simon_pkg;

  localparam int WIDTH      = 4;
  localparam int DEPTH_LOG2 = 6;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [WIDTH-1:0]      pat_t;

  // True when exactly one bit is set. A power of two has no bits left
  // after clearing its lowest set bit.
  function automatic logic popcount_is_one(input logic [31:0] p);
    return (p != 32'd0) && ((p & (p - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/simon_regfile.sv
// Pattern storage: one synchronous write port and one asynchronous read
// port. Contents are not reset.
module simon_regfile
  import simon_pkg::*;
#(
  parameter int WIDTH      = simon_pkg::WIDTH,
  parameter int DEPTH_LOG2 = simon_pkg::DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the selected entry on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read is combinational so a fresh write is visible right after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: pattern register file, the saturating last/i
// pointers and the status flags the control FSM branches on.
module simon_datapath
  import simon_pkg::*;
#(
  parameter int WIDTH      = simon_pkg::WIDTH,
  parameter int DEPTH_LOG2 = simon_pkg::DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pattern,
  input  logic             last_inc,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic             mem_ld,
  input  logic             s_led_eq_pat,
  output logic             i_lt_last,
  output logic             arr_full,
  output logic             correct_pat,
  output logic             legal,
  output logic [WIDTH-1:0] pattern_leds
);

  localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] last;
  logic [DEPTH_LOG2-1:0] i;
  logic [WIDTH-1:0]      mem_rd;
  logic                  i_full;

  assign arr_full = (last == PTR_MAX);
  assign i_full   = (i == PTR_MAX);

  simon_regfile #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_regfile (
    .clk   (clk),
    .we    (mem_ld),
    .waddr (last),
    .wdata (pattern),
    .raddr (i),
    .rdata (mem_rd)
  );

  // Newest-entry pointer; holds at the top entry instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last <= '0;
    else if (last_inc && !arr_full) last <= last + PTR_ONE;
  end

  // Playback pointer; clear has priority over increment, which saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    i <= '0;
    else if (i_clr)             i <= '0;
    else if (i_inc && !i_full)  i <= i + PTR_ONE;
  end

  assign i_lt_last    = (i < last);
  assign correct_pat  = (pattern == mem_rd);
  assign legal        = popcount_is_one(32'(pattern));
  assign pattern_leds = s_led_eq_pat ? pattern : mem_rd;

endmodule
